// File: rtl/rv32i_mem_responder.sv
// rv32i_mem_responder
//   Responder for the core's data-memory requests. Executes RV32I
//   LB/LH/LW/LBU/LHU/SB/SH/SW against a 16-bit synchronous BRAM using one or
//   two halfword accesses per request. Loads come back sign/zero extended;
//   misaligned or illegal requests complete with error_o and touch no memory.
// Ports
//   clk_i, reset_i           clock, synchronous active-high reset
//   addr_i, word_size_i      byte address and funct3 of the request
//   read_i, write_i          load / store request, sampled only when idle
//   wdata_i                  store data
//   rdata_o                  load result, held until the next load completes
//   done_o, error_o          one-cycle completion pulse, error qualifier
//   busy_o                   high while a request is in flight
//   mem_addr_o, mem_wdata_o  BRAM halfword address / write data
//   mem_wmask_o              byte enables (bit0 = [7:0], bit1 = [15:8])
//   mem_read_o, mem_write_o  BRAM strobes, one cycle each
//   mem_rdata_i              BRAM read data, one cycle after mem_read_o
module rv32i_mem_responder #(
  parameter int XLEN          = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [XLEN-1:0]          addr_i,
  input  logic [2:0]               word_size_i,
  input  logic                     read_i,
  input  logic                     write_i,
  input  logic [XLEN-1:0]          wdata_i,
  output logic [XLEN-1:0]          rdata_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic                     busy_o,
  output logic [MEM_ADDR_BITS-1:0] mem_addr_o,
  output logic [15:0]              mem_wdata_o,
  output logic [1:0]               mem_wmask_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  input  logic [15:0]              mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, RD_RESP, WR_LO, WR_HI, ERR
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_e                   state_q;
  logic [MEM_ADDR_BITS-1:0] ha_q;
  logic                     bsel_q;   // addr[0], selects the byte lane on loads
  logic [1:0]               size_q;
  logic                     uns_q;
  logic [15:0]              whi_q;    // upper store half for SW
  logic [15:0]              lo_q;     // lower load half for LW
  logic [XLEN-1:0]          rdata_q;
  logic                     done_q, error_q, mrd_q, mwr_q;
  logic [MEM_ADDR_BITS-1:0] maddr_q;
  logic [15:0]              mwdata_q;
  logic [1:0]               mwmask_q;

  logic [MEM_ADDR_BITS-1:0] ha_d;
  logic                     legal_d;
  logic [15:0]              st_wdata_d;
  logic [1:0]               st_mask_d;
  logic [7:0]               ld_byte_d;
  logic [XLEN-1:0]          ld_ext_d;

  // Bits above the BRAM address range alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[XLEN-1:MEM_ADDR_BITS+1];

  assign ha_d = addr_i[MEM_ADDR_BITS:1];

  always_comb begin
    legal_d = 1'b1;
    if (read_i && write_i)
      legal_d = 1'b0;
    else if (write_i)
      legal_d = (word_size_i == 3'b000) || (word_size_i == 3'b001) || (word_size_i == 3'b010);
    else
      legal_d = (word_size_i == 3'b000) || (word_size_i == 3'b001) || (word_size_i == 3'b010) ||
                (word_size_i == 3'b100) || (word_size_i == 3'b101);
    if (word_size_i[1:0] == SZ_H && addr_i[0])         legal_d = 1'b0;
    if (word_size_i[1:0] == SZ_W && addr_i[1:0] != 2'b00) legal_d = 1'b0;
  end

  always_comb begin
    st_wdata_d = wdata_i[15:0];
    st_mask_d  = 2'b11;
    if (word_size_i[1:0] == SZ_B) begin
      st_wdata_d = {2{wdata_i[7:0]}};
      st_mask_d  = addr_i[0] ? 2'b10 : 2'b01;
    end
  end

  // Extension of the halfword arriving from the BRAM while in RD_RESP.
  always_comb begin
    ld_byte_d = bsel_q ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
    case (size_q)
      SZ_B:    ld_ext_d = {{(XLEN-8){ld_byte_d[7] & ~uns_q}}, ld_byte_d};
      SZ_H:    ld_ext_d = {{(XLEN-16){mem_rdata_i[15] & ~uns_q}}, mem_rdata_i};
      default: ld_ext_d = XLEN'({mem_rdata_i, lo_q});
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ha_q     <= '0;
      bsel_q   <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      whi_q    <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwmask_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      case (state_q)
        IDLE: if (read_i || write_i) begin
          ha_q   <= ha_d;
          bsel_q <= addr_i[0];
          size_q <= word_size_i[1:0];
          uns_q  <= word_size_i[2];
          whi_q  <= wdata_i[31:16];
          if (!legal_d) begin
            done_q  <= 1'b1;
            error_q <= 1'b1;
            state_q <= ERR;
          end else if (read_i) begin
            mrd_q   <= 1'b1;
            maddr_q <= ha_d;
            state_q <= RD_LO;
          end else begin
            mwr_q    <= 1'b1;
            maddr_q  <= ha_d;
            mwdata_q <= st_wdata_d;
            mwmask_q <= st_mask_d;
            state_q  <= WR_LO;
          end
        end
        RD_LO: begin
          if (size_q == SZ_W) begin
            // Word is aligned, so ha is even and ha+1 never carries.
            mrd_q   <= 1'b1;
            maddr_q <= {ha_q[MEM_ADDR_BITS-1:1], 1'b1};
            state_q <= RD_HI;
          end else begin
            state_q <= RD_RESP;
          end
        end
        RD_HI: begin
          lo_q    <= mem_rdata_i;
          state_q <= RD_RESP;
        end
        RD_RESP: begin
          rdata_q <= ld_ext_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        WR_LO: begin
          if (size_q == SZ_W) begin
            mwr_q    <= 1'b1;
            maddr_q  <= {ha_q[MEM_ADDR_BITS-1:1], 1'b1};
            mwdata_q <= whi_q;
            mwmask_q <= 2'b11;
            state_q  <= WR_HI;
          end else begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        WR_HI: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;  // ERR and any stray encoding
      endcase
    end
  end

  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign busy_o      = (state_q != IDLE);
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = mwdata_q;
  assign mem_wmask_o = mwmask_q;
  // Reset kills a strobe already on the bus so an aborted SW cannot reach ha+1.
  assign mem_read_o  = mrd_q & ~reset_i;
  assign mem_write_o = mwr_q & ~reset_i;

endmodule
